// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I opcode and branch predictor types
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_counter_t;

    localparam int BTB_NUM_ENTRIES = 32;

    function automatic logic is_ctrl_flow(input rv32i_opcode op);
        return (op == op_br) || (op == op_jal) || (op == op_jalr);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-state function
module sat_counter2 (
    input  logic [1:0] count,
    input  logic       taken,
    output logic [1:0] next_count
);

    always_comb begin
        next_count = count;
        if (taken) begin
            if (count != 2'b11) next_count = count + 2'b01;
        end else begin
            if (count != 2'b00) next_count = count - 2'b01;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit direction counters
module branch_target_predictor
    import rv32i_types::*;
#(
    parameter int NUM_ENTRIES = BTB_NUM_ENTRIES,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        prediction,
    output logic [31:0] btb_out,
    input  logic        upd_valid,
    input  rv32i_opcode upd_opcode,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] br_count,
    output logic [31:0] mispredict_count
);

    localparam int TAG_W = 30 - IDX_W;

    logic              valid_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]  tag_q    [NUM_ENTRIES];
    logic [31:0]       target_q [NUM_ENTRIES];
    bp_counter_t       ctr_q    [NUM_ENTRIES];

    logic [IDX_W-1:0]  fetch_idx;
    logic [TAG_W-1:0]  fetch_tag;
    logic              fetch_hit;

    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_en;
    logic              upd_hit;
    logic              upd_is_jump;
    logic [1:0]        sat_next;
    bp_counter_t       new_ctr;
    logic [31:0]       new_target;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[31:IDX_W+2];
    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    assign prediction = fetch_hit && ctr_q[fetch_idx][1];
    assign btb_out    = prediction ? target_q[fetch_idx] : fetch_pc + 32'd4;

    assign upd_idx     = upd_pc[IDX_W+1:2];
    assign upd_tag     = upd_pc[31:IDX_W+2];
    assign upd_en      = upd_valid && is_ctrl_flow(upd_opcode);
    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_is_jump = (upd_opcode == op_jal) || (upd_opcode == op_jalr);

    sat_counter2 u_sat_counter2 (
        .count      (ctr_q[upd_idx]),
        .taken      (upd_taken),
        .next_count (sat_next)
    );

    always_comb begin
        new_ctr    = ctr_q[upd_idx];
        new_target = target_q[upd_idx];
        if (upd_is_jump) begin
            new_ctr = ST;
        end else if (upd_hit) begin
            new_ctr = bp_counter_t'(sat_next);
        end else begin
            new_ctr = upd_taken ? WT : WNT;
        end
        // A hit keeps the old target on a not-taken branch; a miss always installs.
        if (!upd_hit || upd_taken) begin
            new_target = upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            br_count         <= '0;
            mispredict_count <= '0;
        end else if (upd_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= new_target;
            ctr_q[upd_idx]    <= new_ctr;
            if (br_count != 32'hFFFF_FFFF) begin
                br_count <= br_count + 32'd1;
            end
            if (upd_mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - scoreboard bench for branch_target_predictor
module tb_branch_target_predictor;
    import rv32i_types::*;

    localparam int N  = 32;
    localparam int IW = $clog2(N);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        prediction;
    logic [31:0] btb_out;
    logic        upd_valid;
    rv32i_opcode upd_opcode;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] br_count;
    logic [31:0] mispredict_count;

    branch_target_predictor #(.NUM_ENTRIES(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .prediction       (prediction),
        .btb_out          (btb_out),
        .upd_valid        (upd_valid),
        .upd_opcode       (upd_opcode),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .br_count         (br_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        pred;
        logic [31:0] btb;
        logic [31:0] brc;
        logic [31:0] misc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_id  = 0;

    // Reference model: one record per set, keyed by the upper PC bits.
    bit          m_valid  [N];
    longint      m_key    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    longint      m_brc;
    longint      m_misc;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic longint mkey(input logic [31:0] pc);
        return longint'(pc) / (4 * N);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_key[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
        m_brc = 0; m_misc = 0;
    endfunction

    function automatic exp_t model_lookup(input logic [31:0] pc);
        exp_t e;
        int   i = midx(pc);
        bit   hit = m_valid[i] && (m_key[i] == mkey(pc));
        e.id   = step_id;
        e.pred = hit && (m_ctr[i] >= 2);
        e.btb  = e.pred ? m_target[i] : pc + 32'd4;
        e.brc  = 32'(m_brc);
        e.misc = 32'(m_misc);
        return e;
    endfunction

    function automatic void model_update();
        int i;
        bit hit;
        bit jump;
        if (rst) begin
            model_reset();
            return;
        end
        if (!upd_valid) return;
        jump = (upd_opcode == op_jal) || (upd_opcode == op_jalr);
        if (!(jump || upd_opcode == op_br)) return;
        if (m_brc < 64'hFFFF_FFFF) m_brc++;
        if (upd_mispredict && m_misc < 64'hFFFF_FFFF) m_misc++;
        i   = midx(upd_pc);
        hit = m_valid[i] && (m_key[i] == mkey(upd_pc));
        if (jump)           m_ctr[i] = 3;
        else if (!hit)      m_ctr[i] = upd_taken ? 2 : 1;
        else if (upd_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        else                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        if (!hit || upd_taken) m_target[i] = upd_target;
        m_valid[i] = 1;
        m_key[i]   = mkey(upd_pc);
    endfunction

    // One cycle: drive inputs, queue expectation, advance the model at the edge.
    // mode 0 = no check, 1 = expectation from model, 2 = expectation given by caller.
    task automatic step(input logic r, input logic [31:0] fpc, input logic uv,
                        input rv32i_opcode op, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic mp, input int mode,
                        input logic xp, input logic [31:0] xb,
                        input logic [31:0] xc, input logic [31:0] xm);
        exp_t e;
        rst = r; fetch_pc = fpc; upd_valid = uv; upd_opcode = op; upd_pc = pc;
        upd_taken = tk; upd_target = tgt; upd_mispredict = mp;
        step_id++;
        e = model_lookup(fpc);
        if (mode == 2) begin
            e.pred = xp; e.btb = xb; e.brc = xc; e.misc = xm;
        end
        if (mode != 0) sb.push_back(e);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input logic [31:0] fpc, input logic xp, input logic [31:0] xb,
                        input logic [31:0] xc, input logic [31:0] xm);
        step(0, fpc, 0, op_imm, 0, 0, 0, 0, 2, xp, xb, xc, xm);
    endtask

    task automatic br(input logic [31:0] fpc, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic xp, input logic [31:0] xb,
                      input logic [31:0] xc);
        step(0, fpc, 1, op_br, pc, tk, tgt, 0, 2, xp, xb, xc, 0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (prediction === e.pred && btb_out === e.btb &&
                br_count === e.brc && mispredict_count === e.misc) begin
                n_pass++;
            end else begin
                $display("FAIL step%0d: got pred=%0b btb=%h br=%0d mis=%0d, expected pred=%0b btb=%h br=%0d mis=%0d",
                         e.id, prediction, btb_out, br_count, mispredict_count,
                         e.pred, e.btb, e.brc, e.misc);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        rv32i_opcode ops [6];
        ops[0] = op_br; ops[1] = op_br; ops[2] = op_jal;
        ops[3] = op_jalr; ops[4] = op_load; ops[5] = op_store;
        model_reset();
        step(1, 0, 0, op_imm, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, op_imm, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        idle(32'h60, 0, 32'h64, 0, 0);
        br(32'h60, 32'h60, 1, 32'h100, 0, 32'h64, 0);
        idle(32'h60, 1, 32'h100, 1, 0);
        br(32'h60, 32'h60, 0, 32'h0, 1, 32'h100, 1);
        br(32'h60, 32'h60, 0, 32'h0, 0, 32'h64, 2);
        idle(32'h60, 0, 32'h64, 3, 0);
        br(32'h60, 32'h60, 1, 32'h100, 0, 32'h64, 3);
        br(32'h60, 32'h60, 1, 32'h100, 0, 32'h64, 4);
        br(32'h60, 32'h60, 1, 32'h100, 1, 32'h100, 5);
        br(32'h60, 32'h60, 1, 32'h100, 1, 32'h100, 6);
        br(32'h60, 32'h60, 0, 32'h0, 1, 32'h100, 7);
        idle(32'h60, 1, 32'h100, 8, 0);
        step(0, 32'h60, 1, op_load, 32'h60, 1, 32'h999, 0, 2, 1, 32'h100, 8, 0);
        idle(32'h60, 1, 32'h100, 8, 0);
        step(0, 32'h80, 1, op_jal, 32'h80, 1, 32'h200, 0, 2, 0, 32'h84, 8, 0);
        idle(32'h80, 1, 32'h200, 9, 0);
        br(32'h80, 32'h80 + 4 * N, 0, 32'h0, 1, 32'h200, 9);
        idle(32'h80, 0, 32'h84, 10, 0);

        step(1, 0, 0, op_imm, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 32'h0, 1, op_br, 32'h200 + 4 * i, 1, 32'h1000 + 16 * i,
                 (i == 1 || i == 4 || i == 7), 2, 0, 32'h4, i, (i > 1) + (i > 4) + (i > 7));
        end
        idle(32'h204, 1, 32'h1010, 10, 3);
        step(1, 32'h0, 1, op_jal, 32'h300, 1, 32'h400, 1, 0, 0, 0, 0, 0);
        idle(32'h300, 0, 32'h304, 0, 0);
        idle(32'h204, 0, 32'h208, 0, 0);

        for (int c = 0; c < 600; c++) begin
            rv32i_opcode op;
            logic        tk;
            op = ops[$urandom_range(0, 5)];
            tk = (op == op_jal || op == op_jalr) ? 1'b1 : 1'($urandom_range(0, 1));
            pc = ($urandom_range(0, 2) << (IW + 2)) | ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 9) == 0) pc = $urandom & 32'hFFFF_FFFC;
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) << (IW + 2)) | ($urandom_range(0, 7) << 2),
                 ($urandom_range(0, 9) < 7), op, pc, tk, $urandom & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)), 1, 0, 0, 0, 0);
        end

        @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
